// File: rtl/lstm_ctrl_pkg.sv
// Purpose: shared types, defaults and helpers for the LSTM BPTT sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lstm_ctrl_pkg;

    // Sequencer states, in the order a sample walks through them.
    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_TLOAD   = 4'd1,
        ST_CALC    = 4'd2,
        ST_LOAD_IN = 4'd3,
        ST_LOAD_H  = 4'd4,
        ST_BP_WAIT = 4'd5,
        ST_WRITE   = 4'd6,
        ST_SETTLE  = 4'd7,
        ST_DONE    = 4'd8
    } state_t;

    localparam int DEF_NUM_ITERATIONS = 8;
    localparam int DEF_CALC_CYCLES    = 44;
    localparam int DEF_BP_CYCLES      = 44;

    // Number of bits needed to hold values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seq_down_cnt.sv
// Purpose: loadable down-counter with zero flag, used to time dwell states.
// Latency: load/decrement take effect on the next clock; o_zero is combinational from the count.
// Backpressure: none; the counter stops at zero.
//
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   i_clr         synchronous clear to 0 (highest priority)
//   i_load        load i_load_val
//   i_dec         decrement by one unless already zero
//   o_zero        count equals 0
module seq_down_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/lstm_bptt_seq_ctrl.sv
// Purpose: drives LSTM backprop array controls (target load, timesteps, backprop wait, weight write) per sample.
// Latency: i_start sampled at edge k gives o_load_t=1 right after that edge; N+N*(CALC+2)+BP+2 cycles per sample.
// Backpressure: none; i_start is ignored while a run is in progress, i_abort always returns to IDLE.
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   i_start         start a run (sampled in IDLE only); i_num_samples latched at the same edge
//   i_abort         synchronous abort back to IDLE, beats i_start
//   o_busy/o_done   run in progress / one-cycle end-of-run pulse
//   o_sel, o_load_* , o_wr, o_addr_t   array control strobes and target address
//   o_sample_idx    index of the sample being processed
import lstm_ctrl_pkg::*;

module lstm_bptt_seq_ctrl #(
    parameter int WIDTH          = 32,
    parameter int NUM_ITERATIONS = DEF_NUM_ITERATIONS,
    parameter int CALC_CYCLES    = DEF_CALC_CYCLES,
    parameter int BP_CYCLES      = DEF_BP_CYCLES,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [CNT_W-1:0] i_num_samples,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_sel,
    output logic             o_load_in,
    output logic             o_load_h,
    output logic             o_load_bp,
    output logic             o_load_t,
    output logic             o_wr,
    output logic [WIDTH-1:0] o_addr_t,
    output logic [CNT_W-1:0] o_sample_idx
);

    // Dwell counter only has to hold (longest dwell - 1).
    localparam int DWELL_MAX = max3(NUM_ITERATIONS, CALC_CYCLES, BP_CYCLES);
    localparam int DW_W      = (clog2(DWELL_MAX) < 1) ? 1 : clog2(DWELL_MAX);

    localparam logic [DW_W-1:0]  TL_LAST     = DW_W'(NUM_ITERATIONS - 1);
    localparam logic [DW_W-1:0]  CALC_LAST   = DW_W'((CALC_CYCLES > 0) ? CALC_CYCLES - 1 : 0);
    localparam logic [DW_W-1:0]  BP_LAST     = DW_W'((BP_CYCLES > 0) ? BP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(NUM_ITERATIONS - 1);
    localparam logic [WIDTH-1:0] BASE_STRIDE = WIDTH'(NUM_ITERATIONS);
    localparam bit               HAS_CALC    = (CALC_CYCLES > 0);
    localparam bit               HAS_BP      = (BP_CYCLES > 0);

    state_t           r_state;
    state_t           w_next;

    logic             w_cnt_clr;
    logic             w_cnt_load;
    logic [DW_W-1:0]  w_cnt_val;
    logic             w_cnt_dec;
    logic             w_cnt_zero;

    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] r_idx;
    logic [CNT_W-1:0] r_step;
    logic [WIDTH-1:0] r_base;
    logic [WIDTH-1:0] w_tload_base;

    logic             r_busy;
    logic             r_done;
    logic             r_sel;
    logic             r_load_in;
    logic             r_load_h;
    logic             r_load_bp;
    logic             r_load_t;
    logic             r_wr;
    logic [WIDTH-1:0] r_addr_t;

    seq_down_cnt #(
        .W(DW_W)
    ) u_dwell_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_cnt_clr),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    // Next state plus dwell-counter control. A dwell state is entered with
    // its length-1 preloaded and exits on the cycle the counter reads zero.
    // Zero-length CALC/BP_WAIT windows are skipped entirely.
    always_comb begin
        w_next     = r_state;
        w_cnt_load = 1'b0;
        w_cnt_val  = '0;
        w_cnt_dec  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_num_samples == '0) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next     = ST_TLOAD;
                        w_cnt_load = 1'b1;
                        w_cnt_val  = TL_LAST;
                    end
                end
            end
            ST_TLOAD: begin
                if (w_cnt_zero) begin
                    if (HAS_CALC) begin
                        w_next     = ST_CALC;
                        w_cnt_load = 1'b1;
                        w_cnt_val  = CALC_LAST;
                    end else begin
                        w_next = ST_LOAD_IN;
                    end
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_CALC: begin
                if (w_cnt_zero) begin
                    w_next = ST_LOAD_IN;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_LOAD_IN: begin
                w_next = ST_LOAD_H;
            end
            ST_LOAD_H: begin
                if (r_step == STEP_LAST) begin
                    if (HAS_BP) begin
                        w_next     = ST_BP_WAIT;
                        w_cnt_load = 1'b1;
                        w_cnt_val  = BP_LAST;
                    end else begin
                        w_next = ST_WRITE;
                    end
                end else if (HAS_CALC) begin
                    w_next     = ST_CALC;
                    w_cnt_load = 1'b1;
                    w_cnt_val  = CALC_LAST;
                end else begin
                    w_next = ST_LOAD_IN;
                end
            end
            ST_BP_WAIT: begin
                if (w_cnt_zero) begin
                    w_next = ST_WRITE;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_WRITE: begin
                w_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                // Compare against the pre-increment index: this sample was the last one.
                if ((r_idx + CNT_W'(1)) == r_num) begin
                    w_next = ST_DONE;
                end else begin
                    w_next     = ST_TLOAD;
                    w_cnt_load = 1'b1;
                    w_cnt_val  = TL_LAST;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase

        // Abort wins over everything, including a same-cycle start in IDLE.
        if (i_abort) begin
            w_next     = ST_IDLE;
            w_cnt_load = 1'b0;
            w_cnt_dec  = 1'b0;
        end
    end

    assign w_cnt_clr = (w_next == ST_IDLE);

    // First target address of the TLOAD window being entered.
    always_comb begin
        w_tload_base = r_base;
        if (r_state == ST_IDLE) begin
            w_tload_base = '0;
        end else if (r_state == ST_SETTLE) begin
            w_tload_base = r_base + BASE_STRIDE;
        end
    end

    // State register and registered outputs, all derived from the state being
    // entered so each output is valid in the cycle its state is occupied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_num     <= '0;
            r_idx     <= '0;
            r_step    <= '0;
            r_base    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sel     <= 1'b0;
            r_load_in <= 1'b0;
            r_load_h  <= 1'b0;
            r_load_bp <= 1'b0;
            r_load_t  <= 1'b0;
            r_wr      <= 1'b0;
            r_addr_t  <= '0;
        end else begin
            r_state <= w_next;
            if (w_next == ST_IDLE) begin
                // Normal end of run and abort both land here with everything cleared.
                r_num     <= '0;
                r_idx     <= '0;
                r_step    <= '0;
                r_base    <= '0;
                r_busy    <= 1'b0;
                r_done    <= 1'b0;
                r_sel     <= 1'b0;
                r_load_in <= 1'b0;
                r_load_h  <= 1'b0;
                r_load_bp <= 1'b0;
                r_load_t  <= 1'b0;
                r_wr      <= 1'b0;
                r_addr_t  <= '0;
            end else begin
                r_busy    <= (w_next != ST_DONE);
                r_done    <= (w_next == ST_DONE);
                r_load_t  <= (w_next == ST_TLOAD);
                r_load_in <= (w_next == ST_LOAD_IN);
                r_load_h  <= (w_next == ST_LOAD_H);
                r_load_bp <= (w_next == ST_LOAD_H);
                r_wr      <= (w_next == ST_WRITE);

                // Address walks base..base+N-1 during TLOAD and holds otherwise.
                if (w_next == ST_TLOAD) begin
                    r_addr_t <= (r_state == ST_TLOAD) ? (r_addr_t + WIDTH'(1)) : w_tload_base;
                end

                case (r_state)
                    ST_IDLE: begin
                        r_num  <= i_num_samples;
                        r_idx  <= '0;
                        r_base <= '0;
                        r_step <= '0;
                        r_sel  <= 1'b0;
                    end
                    ST_LOAD_H: begin
                        // Every timestep after the first is recurrent.
                        r_sel  <= 1'b1;
                        r_step <= r_step + CNT_W'(1);
                    end
                    ST_WRITE: begin
                        r_sel <= 1'b0;
                    end
                    ST_SETTLE: begin
                        r_base <= w_tload_base;
                        r_idx  <= r_idx + CNT_W'(1);
                        r_step <= '0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_sel        = r_sel;
    assign o_load_in    = r_load_in;
    assign o_load_h     = r_load_h;
    assign o_load_bp    = r_load_bp;
    assign o_load_t     = r_load_t;
    assign o_wr         = r_wr;
    assign o_addr_t     = r_addr_t;
    assign o_sample_idx = r_idx;

endmodule

// File: tb/tb_lstm_bptt_seq_ctrl.sv
// Purpose: self-checking bench for lstm_bptt_seq_ctrl against a per-sample timeline model.
// Latency: n/a.
// Backpressure: n/a.
module tb_lstm_bptt_seq_ctrl;

    localparam int N          = 3;
    localparam int C          = 4;
    localparam int B          = 2;
    localparam int W          = 4;   // narrow address so base wraps within a few samples
    localparam int CW         = 16;
    localparam int PER_SAMPLE = N + N * (C + 2) + B + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic          i_abort;
    logic [CW-1:0] i_num_samples;
    logic          o_busy, o_done, o_sel, o_load_in, o_load_h, o_load_bp, o_load_t, o_wr;
    logic [W-1:0]  o_addr_t;
    logic [CW-1:0] o_sample_idx;

    always #5 clk = ~clk;

    lstm_bptt_seq_ctrl #(
        .WIDTH          (W),
        .NUM_ITERATIONS (N),
        .CALC_CYCLES    (C),
        .BP_CYCLES      (B),
        .CNT_W          (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (i_start),
        .i_abort       (i_abort),
        .i_num_samples (i_num_samples),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_sel         (o_sel),
        .o_load_in     (o_load_in),
        .o_load_h      (o_load_h),
        .o_load_bp     (o_load_bp),
        .o_load_t      (o_load_t),
        .o_wr          (o_wr),
        .o_addr_t      (o_addr_t),
        .o_sample_idx  (o_sample_idx)
    );

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          sel;
        logic          lin;
        logic          lh;
        logic          lbp;
        logic          lt;
        logic          wr;
        logic [W-1:0]  addr;
        logic [CW-1:0] idx;
    } exp_t;

    // Model: a run is expanded into its full per-cycle output timeline at start.
    exp_t q[$];
    exp_t cur = '0;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    logic prev_lt = 1'b0;
    int lt_first[$];
    int lin_times[$];
    int wr_times[$];
    int done_times[$];
    logic [W-1:0] lt_addrs[$];

    function automatic exp_t mk(input logic busy, input logic done, input logic sel,
                                input logic lin, input logic lh, input logic lt,
                                input logic wr, input int addr, input int idx);
        exp_t e;
        e.busy = busy;
        e.done = done;
        e.sel  = sel;
        e.lin  = lin;
        e.lh   = lh;
        e.lbp  = lh;
        e.lt   = lt;
        e.wr   = wr;
        e.addr = W'(addr);
        e.idx  = CW'(idx);
        return e;
    endfunction

    task automatic build(input int num);
        int last;
        last = 0;
        if (num == 0) begin
            q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
            return;
        end
        for (int s = 0; s < num; s++) begin
            for (int k = 0; k < N; k++) begin
                last = (s * N + k) % (1 << W);
                q.push_back(mk(1, 0, 0, 0, 0, 1, 0, last, s));
            end
            for (int t = 0; t < N; t++) begin
                for (int c = 0; c < C; c++) q.push_back(mk(1, 0, t > 0, 0, 0, 0, 0, last, s));
                q.push_back(mk(1, 0, t > 0, 1, 0, 0, 0, last, s));
                q.push_back(mk(1, 0, t > 0, 0, 1, 0, 0, last, s));
            end
            for (int b = 0; b < B; b++) q.push_back(mk(1, 0, 1, 0, 0, 0, 0, last, s));
            q.push_back(mk(1, 0, 1, 0, 0, 0, 1, last, s));
            q.push_back(mk(1, 0, 0, 0, 0, 0, 0, last, s));
        end
        q.push_back(mk(0, 1, 0, 0, 0, 0, 0, last, num));
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            cur = '0;
        end else if (i_abort) begin
            q.delete();
            cur = '0;
        end else if (q.size() > 0) begin
            cur = q.pop_front();
        end else if (!cur.busy && !cur.done && i_start) begin
            build(int'(i_num_samples));
            cur = q.pop_front();
        end else begin
            cur = '0;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    function automatic exp_t dut_vec();
        return {o_busy, o_done, o_sel, o_load_in, o_load_h, o_load_bp, o_load_t, o_wr,
                o_addr_t, o_sample_idx};
    endfunction

    // Per-cycle compare and event log, called on each falling edge.
    task automatic sample();
        exp_t act;
        cyc++;
        act = dut_vec();
        checks++;
        if (act !== cur) begin
            fails++;
            $display("FAIL outputs cyc=%0d got=%h expected=%h (busy,done,sel,in,h,bp,t,wr,addr,idx)",
                     cyc, act, cur);
        end
        checks++;
        if (!($onehot0({o_load_in, o_load_h, o_load_t, o_wr}) && (o_load_bp == o_load_h))) begin
            fails++;
            $display("FAIL strobe_excl cyc=%0d got in%b h%b bp%b t%b wr%b", cyc,
                     o_load_in, o_load_h, o_load_bp, o_load_t, o_wr);
        end
        if (o_load_t) begin
            lt_addrs.push_back(o_addr_t);
            if (!prev_lt) lt_first.push_back(cyc);
        end
        prev_lt = o_load_t;
        if (o_load_in) lin_times.push_back(cyc);
        if (o_wr)      wr_times.push_back(cyc);
        if (o_done)    done_times.push_back(cyc);
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int num);
        i_num_samples = CW'(num);
        i_start       = 1'b1;
        tick();
        i_start       = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((cur.busy || cur.done || q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_idle"}, {30'd0, o_busy, o_done}, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c_d, w0, d0, l0, a0, li0, t0;
        rst           = 1'b1;
        i_start       = 1'b0;
        i_abort       = 1'b0;
        i_num_samples = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 32'(dut_vec()), 0);
        tick();
        rst = 1'b0;
        tick();

        // Single sample: hand-derived offsets from first load_t:
        // first load_in = N+C = 7, wr = N+N*(C+2)+B = 23, done = 25.
        c_d = cyc; w0 = wr_times.size(); d0 = done_times.size();
        l0 = lt_first.size(); a0 = lt_addrs.size(); li0 = lin_times.size();
        start(1);
        wait_idle("s1", PER_SAMPLE + 10);
        chk("s1_wr_count", wr_times.size() - w0, 1);
        chk("s1_done_count", done_times.size() - d0, 1);
        chk("s1_tload_len", lt_addrs.size() - a0, 3);
        if (lt_first.size() > l0 && lt_addrs.size() >= a0 + 3 && wr_times.size() > w0 &&
            done_times.size() > d0 && lin_times.size() > li0) begin
            t0 = lt_first[l0];
            chk("s1_start_latency", t0 - c_d, 2);
            for (int k = 0; k < 3; k++) chk("s1_addr", 32'(lt_addrs[a0 + k]), k);
            chk("s1_first_load_in", lin_times[li0] - t0, 7);
            chk("s1_wr_time", wr_times[w0] - t0, 23);
            chk("s1_done_time", done_times[d0] - t0, 25);
        end

        // Three samples, with a start pulse while busy that must be ignored.
        w0 = wr_times.size(); d0 = done_times.size(); a0 = lt_addrs.size();
        start(3);
        repeat (10) tick();
        i_num_samples = 16'd5;
        i_start       = 1'b1;
        tick();
        i_start       = 1'b0;
        wait_idle("s2", 3 * PER_SAMPLE + 10);
        chk("s2_wr_count", wr_times.size() - w0, 3);
        chk("s2_done_count", done_times.size() - d0, 1);
        chk("s2_tload_cycles", lt_addrs.size() - a0, 9);
        if (wr_times.size() >= w0 + 3 && lt_addrs.size() >= a0 + 9) begin
            chk("s2_wr_gap1", wr_times[w0 + 1] - wr_times[w0], 25);
            chk("s2_wr_gap2", wr_times[w0 + 2] - wr_times[w0 + 1], 25);
            chk("s2_addr_s1", 32'(lt_addrs[a0 + 3]), 3);
            chk("s2_addr_s2", 32'(lt_addrs[a0 + 8]), 8);
        end

        // Zero samples: done the cycle after start, no strobes.
        c_d = cyc; d0 = done_times.size(); l0 = lt_first.size();
        start(0);
        tick();
        chk("s3_done_count", done_times.size() - d0, 1);
        if (done_times.size() > d0) chk("s3_done_time", done_times[d0] - c_d, 2);
        chk("s3_no_tload", lt_first.size() - l0, 0);
        tick();

        // Abort beats a simultaneous start in IDLE.
        l0 = lt_first.size();
        i_num_samples = 16'd2;
        i_start       = 1'b1;
        i_abort       = 1'b1;
        tick();
        i_start       = 1'b0;
        i_abort       = 1'b0;
        tick();
        chk("prio_no_tload", lt_first.size() - l0, 0);

        // Abort in the second CALC window of sample 0 (offset 10 from first load_t).
        w0 = wr_times.size(); d0 = done_times.size();
        start(2);
        repeat (10) tick();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        tick();
        chk("s4_busy_after_abort", o_busy, 0);
        chk("s4_no_wr", wr_times.size() - w0, 0);
        chk("s4_no_done", done_times.size() - d0, 0);
        w0 = wr_times.size();
        start(1);
        wait_idle("s4_restart", PER_SAMPLE + 10);
        chk("s4_restart_wr", wr_times.size() - w0, 1);

        // Asynchronous reset in BP_WAIT (offset 22), after an ignored start while busy.
        w0 = wr_times.size(); d0 = done_times.size();
        start(2);
        repeat (5) tick();
        i_num_samples = 16'd7;
        i_start       = 1'b1;
        tick();
        i_start       = 1'b0;
        repeat (16) tick();
        chk("s5_in_bp_wait", {30'd0, o_busy, o_sel}, 3);
        rst = 1'b1;
        #1;
        chk("s5_async_clear", 32'(dut_vec()), 0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("s5_no_wr", wr_times.size() - w0, 0);
        chk("s5_no_done", done_times.size() - d0, 0);

        // Randomized runs: counts 0..7 (first forces an address wrap), stray starts, random aborts.
        for (int r = 0; r < 12; r++) begin
            int  num;
            int  ab_at;
            bit  do_ab;
            num   = (r == 0) ? 6 : int'($urandom_range(0, 7));
            do_ab = ($urandom_range(0, 3) == 0);
            ab_at = int'($urandom_range(0, 150));
            w0    = wr_times.size();
            start(num);
            for (int c = 0; c < num * PER_SAMPLE + 10; c++) begin
                if (!cur.busy && !cur.done && q.size() == 0) break;
                i_start       = ($urandom_range(0, 19) == 0);
                i_num_samples = CW'($urandom_range(0, 7));
                i_abort       = do_ab && (c == ab_at);
                tick();
            end
            i_start = 1'b0;
            i_abort = 1'b0;
            tick();
            chk("rand_idle", {30'd0, o_busy, o_done}, 0);
            if (!do_ab) chk("rand_wr_count", wr_times.size() - w0, num);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
